// File: rtl/toggle_cover_collector.sv
// rtl/toggle_cover_collector.sv - sticky toggle coverage bitmap with first-hit index output slot
// Each point is reported once per clear, lowest pending index first.
module toggle_cover_collector #(
  parameter int WIDTH       = 58,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 38253
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [63:0]                  out_index,
  output logic [$clog2(WIDTH+1)-1:0]   hit_count,
  output logic                         all_covered
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
    $error("toggle_cover_collector: cover range exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] covered_q, covered_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [CW-1:0]    hit_count_q, hit_count_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_index_q, out_index_d;

  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] pick_mask;
  logic [CW-1:0]    new_cnt;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic             load;

  // Descending scan so the last assignment wins: the lowest set pending bit.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    pick_mask = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_found    = 1'b1;
        sel_idx      = IW'(i);
        pick_mask    = '0;
        pick_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    new_hits = valid & ~covered_q;
    new_cnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_cnt = new_cnt + CW'(new_hits[i]);
    end
  end

  assign load = !out_valid_q || out_ready;

  // A fresh hit is never already pending, so clearing the picked bit and
  // merging new hits in the same edge cannot lose anything.
  always_comb begin
    covered_d   = covered_q | valid;
    pending_d   = (pending_q & ~(load ? pick_mask : '0)) | new_hits;
    hit_count_d = hit_count_q + new_cnt;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    if (load) begin
      out_valid_d = sel_found;
      if (sel_found) begin
        out_index_d = 64'(COVER_INDEX) + 64'(sel_idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      covered_q   <= '0;
      pending_q   <= '0;
      hit_count_q <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else if (clear) begin
      covered_q   <= '0;
      pending_q   <= '0;
      hit_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      covered_q   <= covered_d;
      pending_q   <= pending_d;
      hit_count_q <= hit_count_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign hit_count   = hit_count_q;
  assign all_covered = (hit_count_q == CW'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_collector.sv
// tb/tb_toggle_cover_collector.sv - self-checking bench for toggle_cover_collector
module tb_toggle_cover_collector;

  localparam int W  = 58;
  localparam int CI = 100;
  localparam int HW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic [W-1:0]  valid;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_index;
  logic [HW-1:0] hit_count;
  logic          all_covered;

  int checks = 0;
  int errors = 0;
  logic [63:0]  exp_q[$];
  logic [W-1:0] cov_m;

  always #5 clock = ~clock;

  toggle_cover_collector #(.WIDTH(W), .COVER_INDEX(CI)) dut (
    .clock      (clock),
    .reset      (reset),
    .valid      (valid),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .hit_count  (hit_count),
    .all_covered(all_covered)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: an accepted index must match the oldest expected one.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_emit", out_index, 64'hFFFF_FFFF_FFFF_FFFF);
      else check("emit_index", out_index, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic hit(input logic [W-1:0] vec);
    for (int i = 0; i < W; i++) begin
      if (vec[i] && !cov_m[i]) exp_q.push_back(64'(CI + i));
    end
    cov_m = cov_m | vec;
    valid = vec;
    step();
    valid = '0;
  endtask

  task automatic flush_model();
    exp_q.delete();
    cov_m = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    flush_model();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      step();
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic [W-1:0] hits;
    int           exp_hits;
    logic         exp_all;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{hits: 58'h1 << 5, exp_hits: 1, exp_all: 1'b0};
    tbl[1] = '{hits: 58'h1, exp_hits: 1, exp_all: 1'b0};
    tbl[2] = '{hits: 58'h1 << 57, exp_hits: 1, exp_all: 1'b0};
    tbl[3] = '{hits: (58'h1 << 57) | (58'h1 << 3) | (58'h1 << 10), exp_hits: 3, exp_all: 1'b0};
    tbl[4] = '{hits: 58'h155_5555_5555_5555, exp_hits: 29, exp_all: 1'b0};
    tbl[5] = '{hits: '1, exp_hits: 58, exp_all: 1'b1};

    reset = 1'b1; clear = 1'b0; valid = '0; out_ready = 1'b1; cov_m = '0;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_index", out_index, 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_all_covered", 64'(all_covered), 64'd0);
    reset = 1'b0;

    // Minimum latency and single-cycle presentation.
    hit(58'h1 << 5);
    check("lat_edge_k", 64'(out_valid), 64'd0);
    check("lat_cnt", 64'(hit_count), 64'd1);
    step();
    check("lat_edge_k1_valid", 64'(out_valid), 64'd1);
    check("lat_edge_k1_index", out_index, 64'd105);
    step();
    check("lat_one_cycle", 64'(out_valid), 64'd0);

    foreach (tbl[t]) begin
      do_clear();
      out_ready = 1'b1;
      hit(tbl[t].hits);
      drain("tbl");
      check("tbl_hit_count", 64'(hit_count), 64'(tbl[t].exp_hits));
      check("tbl_all_covered", 64'(all_covered), 64'(tbl[t].exp_all));
    end

    // Backpressure: stable hold, then ascending back-to-back drain.
    do_clear();
    out_ready = 1'b0;
    hit((58'h1 << 57) | (58'h1 << 3) | (58'h1 << 10));
    step();
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_index", out_index, 64'd103);
      step();
    end
    out_ready = 1'b1;
    check("bp_seq0", out_index, 64'd103);
    step();
    check("bp_seq1", out_index, 64'd110);
    step();
    check("bp_seq2", out_index, 64'd157);
    check("bp_seq2_valid", 64'(out_valid), 64'd1);
    step();
    check("bp_done", 64'(out_valid), 64'd0);
    check("bp_count", 64'(hit_count), 64'd3);

    // Repeated hits on one point emit once; a hit during a load is kept.
    do_clear();
    for (int k = 0; k < 3; k++) begin
      hit(58'h1 << 7);
      step();
    end
    drain("rep");
    check("rep_count", 64'(hit_count), 64'd1);
    hit(58'h1 << 20);
    hit(58'h1 << 21);
    drain("overlap");
    check("overlap_count", 64'(hit_count), 64'd3);

    // All points in one cycle stream out with no gap.
    do_clear();
    hit('1);
    step();
    for (int k = 0; k < W; k++) begin
      check("burst_valid", 64'(out_valid), 64'd1);
      step();
    end
    check("burst_end", 64'(out_valid), 64'd0);
    check("burst_all", 64'(all_covered), 64'd1);
    check("burst_empty", 64'(exp_q.size()), 64'd0);

    // Clear drops a presented index; the point can be emitted again.
    do_clear();
    out_ready = 1'b0;
    hit(58'h1 << 2);
    step();
    check("clr_presented", out_index, 64'd102);
    do_clear();
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_count", 64'(hit_count), 64'd0);
    out_ready = 1'b1;
    hit(58'h1 << 2);
    drain("clr_again");
    check("clr_again_count", 64'(hit_count), 64'd1);

    // Reset wins over a simultaneous hit.
    reset = 1'b1;
    valid = 58'h1 << 4;
    step();
    reset = 1'b0;
    valid = '0;
    flush_model();
    step();
    step();
    check("rstv_valid", 64'(out_valid), 64'd0);
    check("rstv_count", 64'(hit_count), 64'd0);
    hit(58'h1 << 4);
    drain("rstv_after");
    check("rstv_after_count", 64'(hit_count), 64'd1);

    // Reset mid-backlog discards everything pending.
    out_ready = 1'b0;
    hit(58'hFF << 8);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    flush_model();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("rstb_valid", 64'(out_valid), 64'd0);
    check("rstb_count", 64'(hit_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
